// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: RATIO input beats form one output word,
// with early flush on s_last and a contiguous per-lane keep mask.
module stream_upsizer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_vld,
  output logic                      s_rdy,
  input  logic [IN_WIDTH-1:0]       s_pld,
  input  logic                      s_last,
  output logic                      m_vld,
  input  logic                      m_rdy,
  output logic [IN_WIDTH*RATIO-1:0] m_pld,
  output logic [RATIO-1:0]          m_keep,
  output logic                      m_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [IN_WIDTH*RATIO-1:0] pld_q, pld_d;
  logic [RATIO-1:0]          keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      vld_q, vld_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      acc;
  logic                      xfer;

  assign s_rdy = !vld_q || m_rdy;
  assign acc   = s_vld && s_rdy;
  assign xfer  = vld_q && m_rdy;

  assign m_vld  = vld_q;
  assign m_pld  = pld_q;
  assign m_keep = keep_q;
  assign m_last = last_q;

  always_comb begin
    pld_d  = pld_q;
    keep_d = keep_q;
    last_d = last_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    // A departing word clears the buffer so a same-cycle
    // accept restarts cleanly at lane 0.
    if (xfer) begin
      vld_d  = 1'b0;
      pld_d  = '0;
      keep_d = '0;
      last_d = 1'b0;
      cnt_d  = '0;
    end
    if (acc) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt_q == CW'(i)) begin
          pld_d[i*IN_WIDTH +: IN_WIDTH] = s_pld;
          keep_d[i] = 1'b1;
        end
      end
      if (s_last || cnt_q == CNT_MAX) begin
        vld_d  = 1'b1;
        last_d = s_last;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pld_q  <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pld_q  <= pld_d;
      keep_q <= keep_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: vector table plus
// backpressure, streaming, reset and RATIO=1 sequences.
module tb_stream_upsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_vld, s_rdy, s_last;
  logic [31:0]  s_pld;
  logic         m_vld, m_rdy, m_last;
  logic [127:0] m_pld;
  logic [3:0]   m_keep;

  logic         b_s_vld, b_s_rdy, b_s_last;
  logic [7:0]   b_s_pld;
  logic         b_m_vld, b_m_rdy, b_m_last;
  logic [7:0]   b_m_pld;
  logic [0:0]   b_m_keep;

  stream_upsizer #(.IN_WIDTH(32), .RATIO(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_pld(s_pld), .s_last(s_last),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_pld(m_pld),
    .m_keep(m_keep), .m_last(m_last)
  );

  stream_upsizer #(.IN_WIDTH(8), .RATIO(1)) u_r1 (
    .clk(clk), .rst_n(rst_n),
    .s_vld(b_s_vld), .s_rdy(b_s_rdy), .s_pld(b_s_pld), .s_last(b_s_last),
    .m_vld(b_m_vld), .m_rdy(b_m_rdy), .m_pld(b_m_pld),
    .m_keep(b_m_keep), .m_last(b_m_last)
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [139:0] act,
                     input logic [139:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] w4(input logic [31:0] l0,
                                      input logic [31:0] l1,
                                      input logic [31:0] l2,
                                      input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    s_vld = 1'b1;
    s_pld = d;
    s_last = l;
    tick();
    s_vld = 1'b0;
    s_last = 1'b0;
  endtask

  typedef struct {
    logic         vld;
    logic [31:0]  pld;
    logic         last;
    logic         rdy;
    logic         e_vld;
    logic [127:0] e_pld;
    logic [3:0]   e_keep;
    logic         e_last;
    logic         e_srdy;
  } vec_t;

  vec_t tv[15];
  logic [7:0] q[$];
  logic [127:0] hold_pld;
  int words;
  int drops;
  int nin;
  int nout;

  initial begin
    tv[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0,
               w4(32'h11, 0, 0, 0), 4'h1, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0,
               w4(32'h11, 32'h22, 0, 0), 4'h3, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0,
               w4(32'h11, 32'h22, 32'h33, 0), 4'h7, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
               w4(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 32'hB, 1'b1, 1'b1, 1'b0,
               w4(32'hA, 0, 0, 0), 4'h1, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1,
               w4(32'hA, 32'hB, 0, 0), 4'h3, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b1,
               w4(32'hA, 32'hB, 0, 0), 4'h3, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
               w4(32'hC, 0, 0, 0), 4'h1, 1'b0, 1'b1};
    tv[10] = '{1'b1, 32'hD, 1'b1, 1'b0, 1'b0,
               w4(32'hC, 0, 0, 0), 4'h1, 1'b0, 1'b1};
    tv[11] = '{1'b1, 32'hE, 1'b0, 1'b0, 1'b1,
               w4(32'hC, 32'hD, 0, 0), 4'h3, 1'b1, 1'b0};
    tv[12] = '{1'b1, 32'hE, 1'b1, 1'b1, 1'b1,
               w4(32'hC, 32'hD, 0, 0), 4'h3, 1'b1, 1'b1};
    tv[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
               w4(32'hE, 0, 0, 0), 4'h1, 1'b1, 1'b1};
    tv[14] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0, 1'b1};

    s_vld = 1'b0; s_pld = '0; s_last = 1'b0; m_rdy = 1'b0;
    b_s_vld = 1'b0; b_s_pld = '0; b_s_last = 1'b0; b_m_rdy = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {m_vld, m_pld, m_keep, m_last, s_rdy},
        {1'b0, 128'h0, 4'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      s_vld = tv[i].vld;
      s_pld = tv[i].pld;
      s_last = tv[i].last;
      m_rdy = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {m_vld, m_pld, m_keep, m_last, s_rdy},
          {tv[i].e_vld, tv[i].e_pld, tv[i].e_keep,
           tv[i].e_last, tv[i].e_srdy});
      tick();
    end

    // backpressure hold, then release with a same-cycle accept
    m_rdy = 1'b0;
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    beat(32'h3, 1'b0);
    beat(32'h4, 1'b0);
    s_vld = 1'b1;
    s_pld = 32'h99;
    hold_pld = w4(32'h1, 32'h2, 32'h3, 32'h4);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("hold%0d", i), {m_vld, m_pld, m_keep, s_rdy},
          {1'b1, hold_pld, 4'hF, 1'b0});
      tick();
    end
    m_rdy = 1'b1;
    s_pld = 32'h55;
    tick();
    s_vld = 1'b0;
    chk("release", {m_vld, m_pld, m_keep},
        {1'b0, w4(32'h55, 0, 0, 0), 4'h1});
    beat(32'h66, 1'b0);
    beat(32'h77, 1'b0);
    beat(32'h88, 1'b0);
    chk("release_word", {m_vld, m_pld, m_keep, m_last},
        {1'b1, w4(32'h55, 32'h66, 32'h77, 32'h88), 4'hF, 1'b0});
    tick();

    // streaming: 32 beats back to back, s_last on the final one
    words = 0;
    drops = 0;
    m_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      s_vld = (c < 32);
      s_pld = 32'h100 + c;
      s_last = (c == 31);
      #1;
      if (!s_rdy) drops++;
      if (m_vld) begin
        chk($sformatf("stream_w%0d", words), {m_pld, m_keep, m_last},
            {w4(32'h100 + 4*words, 32'h101 + 4*words,
                32'h102 + 4*words, 32'h103 + 4*words),
             4'hF, (words == 7)});
        words++;
      end
      tick();
    end
    s_vld = 1'b0;
    s_last = 1'b0;
    chk("stream_words", words, 8);
    chk("stream_drops", drops, 0);

    // asynchronous reset in the middle of a word
    beat(32'hAA, 1'b0);
    beat(32'hBB, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset", {m_vld, m_pld, m_keep, m_last},
        {1'b0, 128'h0, 4'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    beat(32'hC1, 1'b0);
    beat(32'hC2, 1'b0);
    beat(32'hC3, 1'b0);
    beat(32'hC4, 1'b0);
    chk("post_reset_word", {m_vld, m_pld, m_keep, m_last},
        {1'b1, w4(32'hC1, 32'hC2, 32'hC3, 32'hC4), 4'hF, 1'b0});
    tick();

    // RATIO=1 forward slice against a FIFO scoreboard
    nin = 0;
    nout = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) begin
        b_m_rdy = (c % 2 == 0);
        b_s_vld = 1'($urandom_range(0, 1));
        b_s_pld = 8'($urandom_range(0, 255));
      end else begin
        b_m_rdy = 1'b1;
        b_s_vld = 1'b0;
      end
      #1;
      if (b_m_vld && b_m_rdy) begin
        if (q.size() == 0) begin
          chk("r1_spurious", 1, 0);
        end else begin
          chk($sformatf("r1_out%0d", nout), {b_m_pld, b_m_keep, b_m_last},
              {q.pop_front(), 1'b1, 1'b0});
        end
        nout++;
      end
      if (b_s_vld && b_s_rdy) begin
        q.push_back(b_s_pld);
        nin++;
      end
      tick();
    end
    chk("r1_count", nout, nin);
    chk("r1_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready stream width converter: packs RATIO consecutive narrow input beats into one wide output beat.
- Early flush when the input marks the end of a packet; partial words carry a per-lane keep mask.
- Sits on the narrow side of a datapath, typically ahead of a register slice feeding a wide consumer.
- Sustains one narrow beat per cycle with no bubbles.

Parameters:
- IN_WIDTH, 32, width of one narrow input beat in bits (>=1).
- RATIO, 4, narrow beats per wide output word (>=1). Counter width is max(1, $clog2(RATIO)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_vld  input  1  input beat valid.
- s_rdy  output  1  input beat ready.
- s_pld  input  IN_WIDTH  input beat payload.
- s_last  input  1  input beat is the last of its packet.
- m_vld  output  1  output word valid.
- m_rdy  input  1  output word ready.
- m_pld  output  IN_WIDTH*RATIO  output word; lane i = bits [i*IN_WIDTH +: IN_WIDTH].
- m_keep  output  RATIO  bit i set = lane i holds valid data.
- m_last  output  1  output word ends a packet.

Behaviour:
- State:
  - Word buffer: buf_pld, buf_keep, buf_last.
  - Lane counter cnt, range 0..RATIO-1.
  - Registered m_vld.
  - m_pld/m_keep/m_last are driven directly from the buffer.
- Reset: m_vld=0, m_pld=0, m_keep=0, m_last=0, cnt=0. s_rdy=1 from the first cycle after reset.
- Reset mid-packet discards any partial word silently.
- Handshake:
  - s_rdy = !m_vld || m_rdy (combinational from m_rdy only, never from s_vld).
  - Input accept: s_vld && s_rdy.
  - Output transfer: m_vld && m_rdy.
- Lane order: first accepted beat of a word goes to lane 0, then lanes ascend (little-endian packing).
- Accept while m_vld=0 (filling):
  - Write s_pld into lane cnt; set buf_keep[cnt].
  - Completing beat is cnt==RATIO-1 or s_last=1. On completion: m_vld<=1, m_last<=s_last, cnt<=0.
  - Otherwise cnt<=cnt+1.
- Accept in the same cycle as an output transfer (m_vld=1, m_rdy=1):
  - Buffer restarts: lane 0 = s_pld, all other lanes and keep bits cleared, keep=1'b1 in lane 0.
  - Completion test applies the same way (RATIO=1 or s_last immediately re-asserts m_vld).
  - This gives back-to-back wide words with no bubble.
- Output transfer with no accept: m_vld<=0; buf_pld, buf_keep, buf_last cleared to 0; cnt=0.
- Hold: while m_vld && !m_rdy, m_pld/m_keep/m_last stay stable and s_rdy=0.
- Unused lanes of a short (s_last-flushed) word read as 0, with matching keep bits 0.
- m_keep is always contiguous from bit 0. The keep of a full word is all ones.
- Latency: m_vld rises the cycle after the completing beat is accepted.
- Throughput: RATIO input beats per output word at 100% input duty while the consumer keeps up.
- RATIO=1: behaves as a full-throughput forward register slice; m_keep=1 whenever m_vld=1.
- s_last on the first beat of a word gives a single-lane word, keep=0...01.
- No combinational path from s_* to m_*.

Test Plan:
- Full word: RATIO=4, IN_WIDTH=32, m_rdy=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles, s_last=0 -> one cycle later m_vld=1, m_pld=0x00000044_00000033_00000022_00000011, m_keep=4'b1111, m_last=0.
- Short packet: beats 0xA, 0xB, second with s_last=1 -> m_pld lanes 0..1 = 0xA, 0xB, lanes 2..3 = 0, m_keep=4'b0011, m_last=1; next word starts at lane 0.
- Backpressure: m_rdy=0 after a full word -> s_rdy=0, m_pld stable for 10 cycles. Release m_rdy while s_vld=1 with beat 0x55 -> transfer and accept in the same cycle; new buffer lane 0 = 0x55, cnt=1, m_vld=0.
- Streaming: 32 beats at s_vld=1, m_rdy=1, s_last on beat 32 -> exactly 8 output words, no s_rdy drop, only word 8 has m_last=1.
- Reset mid-operation: assert rst_n=0 after 2 beats of a word -> m_vld=0, m_keep=0, m_pld=0. After release, 4 new beats produce one word containing only the new data.
- RATIO=1: alternate m_rdy 1/0 for 20 cycles with random s_vld -> output sequence equals input sequence, no loss or duplication, m_keep=1 on every word.
